// File: rtl/sarlock_key_loader.sv
// Serial key loader for the SARLock-locked c432 core: framed key (MSB first + even parity), checked, then driven to keyinput.
// Optional lockout after repeated failures: define SARLOCK_KEY_LOCKOUT_EN.
module sarlock_key_loader #(
  parameter int                 KEY_W     = 16,
  parameter logic [KEY_W-1:0]   DECOY_KEY = 16'h0000,
  parameter int                 TIMEOUT   = 64,
  parameter int                 MAX_FAIL  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_bit_vld,
  output logic             busy,
  output logic [KEY_W-1:0] key_out,
  output logic             key_active,
  output logic             key_done,
  output logic             load_err,
  output logic             locked_out
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(KEY_W);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

`ifdef SARLOCK_KEY_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CHECK, S_ACTIVE, S_ERROR, S_LOCK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CHECK, S_ACTIVE, S_ERROR} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic               parity_q, parity_d;
  logic               in_vld_q, in_vld_d;
  logic               in_bit_q, in_bit_d;
  logic               busy_q, busy_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic               key_active_q, key_active_d;
  logic               key_done_q, key_done_d;
  logic               load_err_q, load_err_d;
`ifdef SARLOCK_KEY_LOCKOUT_EN
  logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic               locked_q, locked_d;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = to_cnt_q;
    shadow_d     = shadow_q;
    parity_d     = parity_q;
    busy_d       = busy_q;
    key_out_d    = key_out_q;
    key_active_d = key_active_q;
    key_done_d   = 1'b0;
    load_err_d   = load_err_q;
`ifdef SARLOCK_KEY_LOCKOUT_EN
    fail_cnt_d   = fail_cnt_q;
    locked_d     = locked_q;
`endif
    // Input stage: bits only count while shifting, and a coincident load_start kills the bit.
    in_vld_d = key_bit_vld & ~load_start & (state_q == S_SHIFT);
    in_bit_d = key_bit;

    case (state_q)
      S_IDLE, S_ACTIVE, S_ERROR: begin
        if (load_start) begin
          state_d      = S_SHIFT;
          bit_cnt_d    = '0;
          to_cnt_d     = '0;
          busy_d       = 1'b1;
          key_active_d = 1'b0;
          key_out_d    = DECOY_KEY;
          load_err_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (load_start) begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end else if (in_vld_q) begin
          to_cnt_d = '0;
          if (bit_cnt_q == PAR_IDX) begin
            parity_d = in_bit_q;
            state_d  = S_CHECK;
          end else begin
            shadow_d  = {shadow_q[KEY_W-2:0], in_bit_q};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d    = S_ERROR;
          to_cnt_d   = '0;
          shadow_d   = '0;
          busy_d     = 1'b0;
          load_err_d = 1'b1;
`ifdef SARLOCK_KEY_LOCKOUT_EN
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_q == FAIL_LAST) begin
            state_d  = S_LOCK;
            locked_d = 1'b1;
          end
`endif
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        busy_d = 1'b0;
        if ((^shadow_q ^ parity_q) == 1'b0) begin
          state_d      = S_ACTIVE;
          key_out_d    = shadow_q;
          key_active_d = 1'b1;
          key_done_d   = 1'b1;
`ifdef SARLOCK_KEY_LOCKOUT_EN
          fail_cnt_d   = '0;
`endif
        end else begin
          state_d    = S_ERROR;
          load_err_d = 1'b1;
`ifdef SARLOCK_KEY_LOCKOUT_EN
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_q == FAIL_LAST) begin
            state_d  = S_LOCK;
            locked_d = 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      shadow_q     <= '0;
      parity_q     <= 1'b0;
      in_vld_q     <= 1'b0;
      in_bit_q     <= 1'b0;
      busy_q       <= 1'b0;
      key_out_q    <= DECOY_KEY;
      key_active_q <= 1'b0;
      key_done_q   <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef SARLOCK_KEY_LOCKOUT_EN
      fail_cnt_q   <= '0;
      locked_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      shadow_q     <= shadow_d;
      parity_q     <= parity_d;
      in_vld_q     <= in_vld_d;
      in_bit_q     <= in_bit_d;
      busy_q       <= busy_d;
      key_out_q    <= key_out_d;
      key_active_q <= key_active_d;
      key_done_q   <= key_done_d;
      load_err_q   <= load_err_d;
`ifdef SARLOCK_KEY_LOCKOUT_EN
      fail_cnt_q   <= fail_cnt_d;
      locked_q     <= locked_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign key_out    = key_out_q;
  assign key_active = key_active_q;
  assign key_done   = key_done_q;
  assign load_err   = load_err_q;
`ifdef SARLOCK_KEY_LOCKOUT_EN
  assign locked_out = locked_q;
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_sarlock_key_loader.sv
// Directed bench for sarlock_key_loader: good/bad frames, timeout, reload, restart, reset, optional lockout.
module tb_sarlock_key_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        key_bit;
  logic        key_bit_vld;
  logic        busy;
  logic [15:0] key_out;
  logic        key_active;
  logic        key_done;
  logic        load_err;
  logic        locked_out;

  int tests_run = 0;
  int tests_failed = 0;

  sarlock_key_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .key_bit(key_bit),
    .key_bit_vld(key_bit_vld), .busy(busy), .key_out(key_out),
    .key_active(key_active), .key_done(key_done), .load_err(load_err),
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] k, input logic p);
    for (int i = 15; i >= 0; i--) begin
      key_bit = k[i];
      key_bit_vld = 1'b1;
      tick();
    end
    key_bit = p;
    tick();
    key_bit_vld = 1'b0;
    key_bit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; key_bit = 1'b0; key_bit_vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if ({busy, key_active, key_done, load_err, locked_out} !== 5'b0 || key_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_state flags=%b key_out=%h expected flags=00000 key_out=0000",
               {busy, key_active, key_done, load_err, locked_out}, key_out);
    end
  endtask

  task automatic test_good_frame();
    pulse_start();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL t1_busy got=%b expected=1", busy);
    end
    send_frame(16'h3563, 1'b0);
    tick();
    tests_run++;
    if (key_active !== 1'b0 || key_done !== 1'b0 || key_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL t1_early active=%b done=%b key_out=%h expected 0 0 0000", key_active, key_done, key_out);
    end
    tick();
    tests_run++;
    if (key_out !== 16'h3563 || key_active !== 1'b1 || key_done !== 1'b1 || load_err !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_accept key_out=%h active=%b done=%b err=%b busy=%b expected 3563 1 1 0 0",
               key_out, key_active, key_done, load_err, busy);
    end
    tick();
    tests_run++;
    if (key_done !== 1'b0 || key_active !== 1'b1) begin
      tests_failed++; $display("FAIL t1_done_pulse done=%b active=%b expected 0 1", key_done, key_active);
    end
  endtask

  task automatic test_bad_parity();
    pulse_start();
    send_frame(16'h3563, 1'b1);
    tick(); tick();
    tests_run++;
    if (load_err !== 1'b1 || key_active !== 1'b0 || key_out !== 16'h0000 || key_done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL t2_reject err=%b active=%b key_out=%h done=%b busy=%b expected 1 0 0000 0 0",
               load_err, key_active, key_out, key_done, busy);
    end
`ifndef SARLOCK_KEY_LOCKOUT_EN
    tests_run++;
    if (locked_out !== 1'b0) begin
      tests_failed++; $display("FAIL t2_locked_tied got=%b expected=0", locked_out);
    end
`endif
    pulse_start();
    tests_run++;
    if (load_err !== 1'b0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL t2_clear err=%b busy=%b expected 0 1", load_err, busy);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      key_bit = 1'b1; key_bit_vld = 1'b1; tick();
    end
    key_bit_vld = 1'b0;
    repeat (60) tick();
    tests_run++;
    if (busy !== 1'b1 || load_err !== 1'b0) begin
      tests_failed++; $display("FAIL t3_before busy=%b err=%b expected 1 0", busy, load_err);
    end
    repeat (10) tick();
    tests_run++;
    if (busy !== 1'b0 || load_err !== 1'b1 || key_out !== 16'h0000 || key_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL t3_expired busy=%b err=%b key_out=%h active=%b expected 0 1 0000 0",
               busy, load_err, key_out, key_active);
    end
    for (int i = 0; i < 20; i++) begin
      key_bit = 1'b1; key_bit_vld = 1'b1; tick();
    end
    key_bit_vld = 1'b0;
    tick(); tick();
    tests_run++;
    if (busy !== 1'b0 || load_err !== 1'b1 || key_active !== 1'b0 || key_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL t3_ignored busy=%b err=%b active=%b done=%b expected 0 1 0 0", busy, load_err, key_active, key_done);
    end
  endtask

  task automatic test_reload();
    pulse_start();
    send_frame(16'h3563, 1'b0);
    tick(); tick();
    tests_run++;
    if (key_out !== 16'h3563 || key_active !== 1'b1) begin
      tests_failed++; $display("FAIL t4_first key_out=%h active=%b expected 3563 1", key_out, key_active);
    end
    pulse_start();
    tests_run++;
    if (key_out !== 16'h0000 || key_active !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL t4_drop key_out=%h active=%b busy=%b expected 0000 0 1", key_out, key_active, busy);
    end
    send_frame(16'hFFFF, 1'b0);
    tick(); tick();
    tests_run++;
    if (key_out !== 16'hFFFF || key_active !== 1'b1 || key_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL t4_reload key_out=%h active=%b done=%b expected ffff 1 1", key_out, key_active, key_done);
    end
  endtask

  task automatic test_restart();
    logic [15:0] junk;
    junk = 16'hAAAA;
    pulse_start();
    for (int i = 15; i >= 7; i--) begin
      key_bit = junk[i]; key_bit_vld = 1'b1; tick();
    end
    key_bit = 1'b1; key_bit_vld = 1'b1; load_start = 1'b1;
    tick();
    load_start = 1'b0; key_bit_vld = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || key_active !== 1'b0) begin
      tests_failed++; $display("FAIL t5_restart busy=%b active=%b expected 1 0", busy, key_active);
    end
    send_frame(16'h1234, 1'b1);
    tick(); tick();
    tests_run++;
    if (key_out !== 16'h1234 || key_active !== 1'b1 || load_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL t5_frame key_out=%h active=%b err=%b expected 1234 1 0", key_out, key_active, load_err);
    end
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      key_bit = 1'b1; key_bit_vld = 1'b1; tick();
    end
    key_bit_vld = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    tests_run++;
    if ({busy, key_active, key_done, load_err, locked_out} !== 5'b0 || key_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL t5_midreset flags=%b key_out=%h expected 00000 0000",
               {busy, key_active, key_done, load_err, locked_out}, key_out);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || key_active !== 1'b0) begin
      tests_failed++; $display("FAIL t5_idle busy=%b active=%b expected 0 0", busy, key_active);
    end
  endtask

`ifdef SARLOCK_KEY_LOCKOUT_EN
  task automatic test_lockout();
    for (int n = 0; n < 3; n++) begin
      pulse_start();
      send_frame(16'h3563, 1'b1);
      tick(); tick();
    end
    tests_run++;
    if (locked_out !== 1'b1 || load_err !== 1'b1 || key_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL t6_locked locked=%b err=%b key_out=%h expected 1 1 0000", locked_out, load_err, key_out);
    end
    pulse_start();
    send_frame(16'h3563, 1'b0);
    tick(); tick();
    tests_run++;
    if (locked_out !== 1'b1 || key_active !== 1'b0 || key_out !== 16'h0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL t6_ignored locked=%b active=%b key_out=%h busy=%b expected 1 0 0000 0",
               locked_out, key_active, key_out, busy);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    tests_run++;
    if (locked_out !== 1'b0) begin
      tests_failed++; $display("FAIL t6_reset locked=%b expected 0", locked_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_timeout();
    test_reload();
    test_restart();
`ifdef SARLOCK_KEY_LOCKOUT_EN
    test_lockout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
